// File: rtl/usb_pkg.sv
// Shared USB host types: transaction results, sequencer states, PIDs, default endpoints.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package usb_pkg;

    typedef enum logic [1:0] {
        RES_ACK     = 2'd0,
        RES_NAK     = 2'd1,
        RES_TIMEOUT = 2'd2,
        RES_CORRUPT = 2'd3
    } txn_res_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_ISSUE,
        S_ADDR_WAIT,
        S_DATA_ISSUE,
        S_DATA_WAIT,
        S_RESP
    } rw_state_t;

    localparam logic [3:0] PID_OUT  = 4'b0001;
    localparam logic [3:0] PID_IN   = 4'b1001;
    localparam logic [3:0] PID_ACK  = 4'b0010;
    localparam logic [3:0] PID_NAK  = 4'b1010;

    localparam logic [3:0] DEF_ADDR_EP = 4'd4;
    localparam logic [3:0] DEF_DATA_EP = 4'd8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/usb_retry_ctr.sv
// Per-transaction attempt counter; exhausted_o flags that the attempt in flight is the last allowed.
// Latency: clear/increment take effect on the next clock.
// Backpressure: none; driven purely by the sequencer.
module usb_retry_ctr #(
    parameter int MAX_RETRY = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic exhausted_o
);

    localparam int CW = $clog2(MAX_RETRY + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts failures so far, so MAX_RETRY-1 means this attempt is the final one.
    assign exhausted_o = (cnt_q == CW'(MAX_RETRY - 1));

endmodule

// File: rtl/usb_rw_engine.sv
// Host read/write sequencer: address OUT to ADDR_EP, then NBEAT OUT/IN beats on DATA_EP; optional USB_RW_STATS_EN counters.
// Latency: 5 cycles accept->resp_valid for one beat with a same-cycle PHY; +2 per extra beat or reissue.
// Backpressure: req_ready only in IDLE; each phase waits on txn_done; resp_valid is a pulse that cannot stall.
module usb_rw_engine
    import usb_pkg::*;
#(
    parameter int         ADDR_W    = 16,
    parameter int         DATA_W    = 64,
    parameter int         MAX_RETRY = 8,
    parameter logic [3:0] ADDR_EP   = DEF_ADDR_EP,
    parameter logic [3:0] DATA_EP   = DEF_DATA_EP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_ok,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              txn_start,
    output logic              txn_in,
    output logic [3:0]        txn_endp,
    output logic [63:0]       txn_wdata,
    input  logic              txn_done,
    input  txn_res_t          txn_result,
    input  logic [63:0]       txn_rdata
`ifdef USB_RW_STATS_EN
    ,
    output logic [15:0]       stat_req,
    output logic [15:0]       stat_fail,
    output logic [15:0]       stat_retry
`endif
);

    localparam int NBEAT  = DATA_W / 64;
    localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    rw_state_t         state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              txn_in_q, txn_in_d;
    logic [3:0]        txn_endp_q, txn_endp_d;
    logic [63:0]       txn_wdata_q, txn_wdata_d;
    logic              resp_ok_q, resp_ok_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic accept;
    logic txn_ack;
    logic retry_clr, retry_inc, retry_exh;

    assign accept  = req_valid && req_ready;
    assign txn_ack = (txn_result == RES_ACK);

    usb_retry_ctr #(
        .MAX_RETRY (MAX_RETRY)
    ) u_retry (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (retry_clr),
        .inc_i       (retry_inc),
        .exhausted_o (retry_exh)
    );

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        beat_d       = beat_q;
        txn_in_d     = txn_in_q;
        txn_endp_d   = txn_endp_q;
        txn_wdata_d  = txn_wdata_q;
        resp_ok_d    = resp_ok_q;
        resp_rdata_d = resp_rdata_q;
        retry_clr    = 1'b0;
        retry_inc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    beat_d  = '0;
                    state_d = S_ADDR_ISSUE;
                end
            end
            S_ADDR_ISSUE: state_d = S_ADDR_WAIT;
            S_DATA_ISSUE: state_d = S_DATA_WAIT;
            S_ADDR_WAIT, S_DATA_WAIT: begin
                if (txn_done && txn_ack) begin
                    retry_clr = 1'b1;
                    if (state_q == S_ADDR_WAIT) begin
                        beat_d  = '0;
                        state_d = S_DATA_ISSUE;
                    end else begin
                        if (!write_q) begin
                            rdata_d[64*int'(beat_q) +: 64] = txn_rdata;
                        end
                        if (beat_q == BEAT_W'(NBEAT - 1)) begin
                            resp_ok_d    = 1'b1;
                            resp_rdata_d = write_q ? '0 : rdata_d;
                            state_d      = S_RESP;
                        end else begin
                            beat_d  = beat_q + BEAT_W'(1);
                            state_d = S_DATA_ISSUE;
                        end
                    end
                end else if (txn_done) begin
                    if (retry_exh) begin
                        // Out of attempts: abandon every remaining phase.
                        retry_clr    = 1'b1;
                        resp_ok_d    = 1'b0;
                        resp_rdata_d = '0;
                        state_d      = S_RESP;
                    end else begin
                        retry_inc = 1'b1;
                        state_d   = (state_q == S_ADDR_WAIT) ? S_ADDR_ISSUE : S_DATA_ISSUE;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Transaction fields are loaded on entry to an issue state and held through the wait.
        if (state_d == S_ADDR_ISSUE) begin
            txn_in_d    = 1'b0;
            txn_endp_d  = ADDR_EP;
            txn_wdata_d = 64'(addr_d);
        end else if (state_d == S_DATA_ISSUE) begin
            txn_in_d    = !write_d;
            txn_endp_d  = DATA_EP;
            txn_wdata_d = write_d ? wdata_d[64*int'(beat_d) +: 64] : 64'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            beat_q       <= '0;
            txn_in_q     <= 1'b0;
            txn_endp_q   <= 4'd0;
            txn_wdata_q  <= 64'd0;
            resp_ok_q    <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            beat_q       <= beat_d;
            txn_in_q     <= txn_in_d;
            txn_endp_q   <= txn_endp_d;
            txn_wdata_q  <= txn_wdata_d;
            resp_ok_q    <= resp_ok_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_ok    = resp_ok_q;
    assign resp_rdata = resp_rdata_q;
    assign txn_start  = (state_q == S_ADDR_ISSUE) || (state_q == S_DATA_ISSUE);
    assign txn_in     = txn_in_q;
    assign txn_endp   = txn_endp_q;
    assign txn_wdata  = txn_wdata_q;

`ifdef USB_RW_STATS_EN
    logic        req_fail;
    logic [15:0] stat_req_q, stat_fail_q, stat_retry_q;

    assign req_fail = txn_done && !txn_ack && retry_exh &&
                      ((state_q == S_ADDR_WAIT) || (state_q == S_DATA_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req_q   <= 16'd0;
            stat_fail_q  <= 16'd0;
            stat_retry_q <= 16'd0;
        end else begin
            if (accept)    stat_req_q   <= sat_inc16(stat_req_q);
            if (req_fail)  stat_fail_q  <= sat_inc16(stat_fail_q);
            if (retry_inc) stat_retry_q <= sat_inc16(stat_retry_q);
        end
    end

    assign stat_req   = stat_req_q;
    assign stat_fail  = stat_fail_q;
    assign stat_retry = stat_retry_q;
`endif

endmodule

// File: tb/tb_usb_rw_engine.sv
// Directed bench for usb_rw_engine: 64-bit and 256-bit instances driven by scripted PHY responders.
module tb_usb_rw_engine;
    import usb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int vectors = 0;
    int miscompares = 0;

    // 64-bit instance
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_ok;
    logic [63:0] resp_rdata;
    logic        txn_start, txn_in;
    logic [3:0]  txn_endp;
    logic [63:0] txn_wdata;
    logic        txn_done;
    txn_res_t    txn_result;
    logic [63:0] txn_rdata;
`ifdef USB_RW_STATS_EN
    logic [15:0] stat_req, stat_fail, stat_retry;
    logic [15:0] b_stat_req, b_stat_fail, b_stat_retry;
`endif

    // 256-bit instance
    logic         b_req_valid, b_req_ready, b_req_write;
    logic [15:0]  b_req_addr;
    logic [255:0] b_req_wdata;
    logic         b_resp_valid, b_resp_ok;
    logic [255:0] b_resp_rdata;
    logic         b_txn_start, b_txn_in;
    logic [3:0]   b_txn_endp;
    logic [63:0]  b_txn_wdata;
    logic         b_txn_done;
    txn_res_t     b_txn_result;
    logic [63:0]  b_txn_rdata;

    usb_rw_engine #(.DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ok(resp_ok), .resp_rdata(resp_rdata),
        .txn_start(txn_start), .txn_in(txn_in), .txn_endp(txn_endp), .txn_wdata(txn_wdata),
        .txn_done(txn_done), .txn_result(txn_result), .txn_rdata(txn_rdata)
`ifdef USB_RW_STATS_EN
        , .stat_req(stat_req), .stat_fail(stat_fail), .stat_retry(stat_retry)
`endif
    );

    usb_rw_engine #(.DATA_W(256)) dut_w (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ok(b_resp_ok), .resp_rdata(b_resp_rdata),
        .txn_start(b_txn_start), .txn_in(b_txn_in), .txn_endp(b_txn_endp), .txn_wdata(b_txn_wdata),
        .txn_done(b_txn_done), .txn_result(b_txn_result), .txn_rdata(b_txn_rdata)
`ifdef USB_RW_STATS_EN
        , .stat_req(b_stat_req), .stat_fail(b_stat_fail), .stat_retry(b_stat_retry)
`endif
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // PHY for the 64-bit instance: scripted results, optional delay, transaction log.
    txn_res_t    res_q[$];
    int          phy_dly = 0;
    logic [63:0] phy_rdata = 64'd0;
    logic [3:0]  log_ep[$];
    logic        log_in[$];
    logic [63:0] log_dat[$];
    int          resp_cnt = 0;
    bit          pend = 0;
    int          pend_cnt = 0;

    initial begin
        txn_done = 1'b0; txn_result = RES_ACK; txn_rdata = 64'd0;
        forever begin
            @(posedge clk); #1;
            txn_done = 1'b0;
            if (resp_valid) resp_cnt++;
            if (pend) begin
                if (pend_cnt == 0) begin
                    txn_done = 1'b1;
                    txn_rdata = phy_rdata;
                    if (res_q.size() > 0) txn_result = res_q.pop_front();
                    else txn_result = RES_ACK;
                    pend = 0;
                end else begin
                    pend_cnt--;
                end
            end
            if (txn_start) begin
                log_ep.push_back(txn_endp); log_in.push_back(txn_in); log_dat.push_back(txn_wdata);
                pend = 1; pend_cnt = phy_dly;
            end
        end
    end

    // PHY for the 256-bit instance: always ACK; IN beat n returns 0x1000+n.
    logic [3:0]  b_log_ep[$];
    logic        b_log_in[$];
    logic [63:0] b_log_dat[$];
    int          b_ep8 = 0;
    bit          b_pend = 0;

    initial begin
        b_txn_done = 1'b0; b_txn_result = RES_ACK; b_txn_rdata = 64'd0;
        forever begin
            @(posedge clk); #1;
            b_txn_done = 1'b0;
            if (b_pend) begin
                b_txn_done = 1'b1;
                b_txn_rdata = 64'h1000 + 64'(b_ep8 - 1);
                b_pend = 0;
            end
            if (b_txn_start) begin
                b_log_ep.push_back(b_txn_endp); b_log_in.push_back(b_txn_in); b_log_dat.push_back(b_txn_wdata);
                if (b_txn_endp == 4'd8) b_ep8++;
                b_pend = 1;
            end
        end
    end

    function automatic int count_ep(input logic [3:0] ep);
        int n = 0;
        foreach (log_ep[i]) if (log_ep[i] == ep) n++;
        return n;
    endfunction

    function automatic void clear_log();
        log_ep.delete(); log_in.delete(); log_dat.delete();
    endfunction

    logic busy_rdy;

    task automatic req0(input logic wr, input logic [15:0] a, input logic [63:0] d, output int lat);
        bit got = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        lat = 0;
        while (!got && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            req_valid = 1'b0;
            if (lat == 1) busy_rdy = req_ready;
            if (resp_valid) got = 1;
        end
        if (!got) check("resp_timeout", 256'd0, 256'd1);
    endtask

    task automatic req1(input logic wr, input logic [15:0] a, input logic [255:0] d);
        bit got = 0;
        int n = 0;
        @(posedge clk); #1;
        b_req_valid = 1'b1; b_req_write = wr; b_req_addr = a; b_req_wdata = d;
        while (!got && n < 300) begin
            @(posedge clk); #1;
            n++;
            b_req_valid = 1'b0;
            if (b_resp_valid) got = 1;
        end
        if (!got) check("w_resp_timeout", 256'd0, 256'd1);
    endtask

    initial begin
        int lat;
        int rc;
        bit seen;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_ok", resp_ok, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_txn_start", txn_start, 0);
        check("rst_txn_in", txn_in, 0);
        check("rst_txn_endp", txn_endp, 0);
        check("rst_txn_wdata", txn_wdata, 0);

        // Write, all ones, always ACK
        clear_log();
        req0(1'b1, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        check("wr_latency", lat, 5);
        check("wr_busy_ready", busy_rdy, 0);
        check("wr_ntxn", log_ep.size(), 2);
        check("wr_addr_ep", log_ep[0], 4);
        check("wr_addr_in", log_in[0], 0);
        check("wr_addr_pay", log_dat[0], 64'h0000_0000_0000_FFFF);
        check("wr_data_ep", log_ep[1], 8);
        check("wr_data_in", log_in[1], 0);
        check("wr_data_pay", log_dat[1], 64'hFFFF_FFFF_FFFF_FFFF);
        check("wr_ok", resp_ok, 1);
        check("wr_rdata", resp_rdata, 0);
        @(posedge clk); #1;
        check("wr_ready_after", req_ready, 1);
        check("wr_resp_pulse", resp_valid, 0);

        // Read
        clear_log();
        phy_rdata = 64'h0000_0000_0000_0100;
        req0(1'b0, 16'h0001, 64'd0, lat);
        check("rd_latency", lat, 5);
        check("rd_ntxn", log_ep.size(), 2);
        check("rd_addr_ep", log_ep[0], 4);
        check("rd_addr_pay", log_dat[0], 64'h1);
        check("rd_data_ep", log_ep[1], 8);
        check("rd_data_in", log_in[1], 1);
        check("rd_ok", resp_ok, 1);
        check("rd_rdata", resp_rdata, 64'h100);

        // Data phase NAKed three times, then ACK
        clear_log();
        res_q = '{RES_ACK, RES_NAK, RES_NAK, RES_NAK};
        req0(1'b1, 16'h1234, 64'hA5A5_5A5A_0F0F_F0F0, lat);
        check("nak_ep4", count_ep(4'd4), 1);
        check("nak_ep8", count_ep(4'd8), 4);
        check("nak_pay", log_dat[4], 64'hA5A5_5A5A_0F0F_F0F0);
        check("nak_ok", resp_ok, 1);
`ifdef USB_RW_STATS_EN
        check("nak_stat_retry", stat_retry, 3);
`endif

        // Address phase times out on every attempt
        clear_log();
        res_q.delete();
        repeat (8) res_q.push_back(RES_TIMEOUT);
        phy_rdata = 64'hDEAD_BEEF_0000_0001;
        req0(1'b0, 16'h0042, 64'd0, lat);
        check("to_ep4", count_ep(4'd4), 8);
        check("to_ep8", count_ep(4'd8), 0);
        check("to_ok", resp_ok, 0);
        check("to_rdata", resp_rdata, 0);
`ifdef USB_RW_STATS_EN
        check("to_stat_req", stat_req, 4);
        check("to_stat_fail", stat_fail, 1);
        check("to_stat_retry", stat_retry, 10);
`endif

        // Seven address failures then ACK; one data NAK proves the count restarted
        clear_log();
        res_q.delete();
        repeat (7) res_q.push_back(RES_CORRUPT);
        res_q.push_back(RES_ACK);
        res_q.push_back(RES_NAK);
        phy_rdata = 64'h55;
        req0(1'b0, 16'h0077, 64'd0, lat);
        check("edge_ep4", count_ep(4'd4), 8);
        check("edge_ep8", count_ep(4'd8), 2);
        check("edge_ok", resp_ok, 1);
        check("edge_rdata", resp_rdata, 64'h55);
        @(posedge clk); #1;
        check("edge_ok_hold", resp_ok, 1);
`ifdef USB_RW_STATS_EN
        check("edge_stat_retry", stat_retry, 18);
`endif

        // Reset while the data phase is outstanding
        clear_log();
        phy_dly = 4;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h00AA; req_wdata = 64'h1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (txn_start && txn_endp == 4'd8) seen = 1;
        end
        check("rst_mid_reach_data", seen, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        rc = resp_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_ready", req_ready, 1);
        check("rst_mid_ok", resp_ok, 0);
        check("rst_mid_endp", txn_endp, 0);
        repeat (15) @(posedge clk);
        #1;
        check("rst_mid_no_resp", resp_cnt, rc);
`ifdef USB_RW_STATS_EN
        check("rst_mid_stat_req", stat_req, 0);
`endif
        phy_dly = 0;
        clear_log();
        req0(1'b1, 16'h0BCD, 64'h0123_4567_89AB_CDEF, lat);
        check("post_rst_latency", lat, 5);
        check("post_rst_ok", resp_ok, 1);
        check("post_rst_pay", log_dat[1], 64'h0123_4567_89AB_CDEF);
`ifdef USB_RW_STATS_EN
        check("post_rst_stat_req", stat_req, 1);
`endif

        // 256-bit write: beats go out lowest word first
        b_log_ep.delete(); b_log_in.delete(); b_log_dat.delete();
        b_ep8 = 0;
        req1(1'b1, 16'h0300, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        check("w256_ntxn", b_log_ep.size(), 5);
        check("w256_addr_pay", b_log_dat[0], 64'h300);
        for (int k = 0; k < 4; k++) begin
            check("w256_beat_ep", b_log_ep[k+1], 8);
            check("w256_beat_pay", b_log_dat[k+1], 64'h1111_1111_1111_1111 * 64'(k + 1));
        end
        check("w256_ok", b_resp_ok, 1);
        check("w256_rdata", b_resp_rdata, 0);

        // 256-bit read: beat n lands at bits [64n+63:64n]
        b_log_ep.delete(); b_log_in.delete(); b_log_dat.delete();
        b_ep8 = 0;
        req1(1'b0, 16'h0007, 256'd0);
        check("r256_beat_in", b_log_in[4], 1);
        check("r256_ok", b_resp_ok, 1);
        check("r256_rdata", b_resp_rdata,
              {64'h1003, 64'h1002, 64'h1001, 64'h1000});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
